// File: rtl/peripheral.sv
// Memory-mapped peripheral at 0x4000_0000: timer with interrupt, LED/7-seg/switch ports, 8N1 UART TX/RX.
// Ports: rd/wr/addr/wdata/rdata CPU bus, switch/led/digi board I/O, PC_Uart_rxd/txd serial, irqout to CPU.
// Optional macro PERIPH_UART_IRQ_EN adds UART_CON[3] rx interrupt enable and ORs the rx term into irqout.
module peripheral #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic        clk,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [7:0]  switch,
   output logic [31:0] rdata,
   output logic [7:0]  led,
   output logic [11:0] digi,
   output logic        irqout,
   input  logic        PC_Uart_rxd,
   output logic        PC_Uart_txd
);
   localparam logic [31:0] BIT_CYC  = 32'(CLK_FREQ / BAUD);
   localparam logic [31:0] HALF_CYC = BIT_CYC >> 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   logic [31:0] wa;
   assign wa = {addr[31:2], 2'b00};

   logic unused_pins;
   assign unused_pins = sysclk ^ addr[1] ^ addr[0];

   logic [31:0] th, tl;
   logic [2:0]  tcon;
   logic [7:0]  tx_data, rx_data;
   logic        tx_done, rx_valid, rx_ie;

   // ---------------- timer ----------------
   logic tl_wrap;
   assign tl_wrap = tcon[0] && (tl == 32'hFFFF_FFFF);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         th <= '0; tl <= '0; tcon <= '0; led <= '0; digi <= '0;
      end else begin
         if (wr && wa == 32'h4000_0000) th <= wdata;
         // CPU writes take priority over counting and status setting
         if (wr && wa == 32'h4000_0004) tl <= wdata;
         else if (tl_wrap)              tl <= th;
         else if (tcon[0])              tl <= tl + 32'd1;
         if (wr && wa == 32'h4000_0008) tcon <= wdata[2:0];
         else if (tl_wrap && tcon[1])   tcon[2] <= 1'b1;
         if (wr && wa == 32'h4000_000C) led  <= wdata[7:0];
         if (wr && wa == 32'h4000_0014) digi <= wdata[11:0];
      end
   end

   // ---------------- UART TX ----------------
   uart_state_t tx_state, tx_state_n;
   logic [31:0] tx_cnt;
   logic [2:0]  tx_bit, tx_bit_n;
   logic        tx_load, tx_fin, tx_bit_end, txd_n;

   assign tx_bit_end = (tx_cnt == BIT_CYC - 32'd1);

   always_comb begin
      tx_state_n = tx_state;
      tx_load    = 1'b0;
      tx_fin     = 1'b0;
      case (tx_state)
         IDLE:  if (wr && wa == 32'h4000_0018) begin tx_state_n = START; tx_load = 1'b1; end
         START: if (tx_bit_end) tx_state_n = DATA;
         DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_state_n = STOP;
         STOP:  if (tx_bit_end) begin tx_state_n = IDLE; tx_fin = 1'b1; end
         default: tx_state_n = IDLE;
      endcase
      tx_bit_n = 3'd0;
      if (tx_state == DATA) tx_bit_n = tx_bit_end ? tx_bit + 3'd1 : tx_bit;
      // txd is registered from the next state so the line follows the state edge exactly
      case (tx_state_n)
         START:   txd_n = 1'b0;
         DATA:    txd_n = tx_data[tx_bit_n];
         default: txd_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state <= IDLE; tx_cnt <= '0; tx_bit <= '0; tx_data <= '0;
         tx_done <= 1'b0; PC_Uart_txd <= 1'b1;
      end else begin
         tx_state    <= tx_state_n;
         tx_bit      <= tx_bit_n;
         PC_Uart_txd <= txd_n;
         tx_cnt      <= (tx_state_n != tx_state || tx_bit_end || tx_state_n == IDLE) ? 32'd0 : tx_cnt + 32'd1;
         if (tx_load) tx_data <= wdata[7:0];
         if (tx_fin)                              tx_done <= 1'b1;
         else if (rd && wa == 32'h4000_0020)      tx_done <= 1'b0;
      end
   end

   // ---------------- UART RX ----------------
   uart_state_t rx_state, rx_state_n;
   logic [31:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift;
   logic        rx_s1, rx_s2, rx_prev, rx_samp, rx_ok;

   assign rx_samp = (rx_state == DATA) && (rx_cnt == BIT_CYC - 32'd1);

   always_comb begin
      rx_state_n = rx_state;
      rx_ok      = 1'b0;
      case (rx_state)
         IDLE:  if (rx_prev && !rx_s2) rx_state_n = START;
         // still high at half a bit: treat as a glitch
         START: if (rx_cnt == HALF_CYC - 32'd1) rx_state_n = rx_s2 ? IDLE : DATA;
         DATA:  if (rx_samp && rx_bit == 3'd7) rx_state_n = STOP;
         STOP:  if (rx_cnt == BIT_CYC - 32'd1) begin rx_state_n = IDLE; rx_ok = rx_s2; end
         default: rx_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
         rx_state <= IDLE; rx_cnt <= '0; rx_bit <= '0; rx_shift <= '0;
         rx_data <= '0; rx_valid <= 1'b0;
      end else begin
         rx_s1    <= PC_Uart_rxd;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_state <= rx_state_n;
         rx_cnt   <= (rx_state_n != rx_state || rx_samp || rx_state_n == IDLE) ? 32'd0 : rx_cnt + 32'd1;
         if (rx_state == START) rx_bit <= 3'd0;
         else if (rx_samp) begin
            rx_bit   <= rx_bit + 3'd1;
            rx_shift <= {rx_s2, rx_shift[7:1]};
         end
         if (rx_ok) rx_data <= rx_shift;
         // a completing byte wins over the read-clear
         if (rx_ok)                               rx_valid <= 1'b1;
         else if (rd && wa == 32'h4000_001C)      rx_valid <= 1'b0;
      end
   end

`ifdef PERIPH_UART_IRQ_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rx_ie <= 1'b0;
      else if (wr && wa == 32'h4000_0020) rx_ie <= wdata[3];
   end
   assign irqout = (tcon[1] & tcon[2]) | (rx_ie & rx_valid);
`else
   assign rx_ie  = 1'b0;
   assign irqout = tcon[1] & tcon[2];
`endif

   // ---------------- read mux ----------------
   always_comb begin
      rdata = 32'd0;
      if (rd) begin
         case (wa)
            32'h4000_0000: rdata = th;
            32'h4000_0004: rdata = tl;
            32'h4000_0008: rdata = {29'd0, tcon};
            32'h4000_000C: rdata = {24'd0, led};
            32'h4000_0010: rdata = {24'd0, switch};
            32'h4000_0014: rdata = {20'd0, digi};
            32'h4000_0018: rdata = {24'd0, tx_data};
            32'h4000_001C: rdata = {24'd0, rx_data};
            32'h4000_0020: rdata = {28'd0, rx_ie, tx_state != IDLE, tx_done, rx_valid};
            default:       rdata = 32'd0;
         endcase
      end
   end
endmodule

// File: tb/tb_peripheral.sv
// Directed bench for peripheral with a 10-cycle UART bit period (CLK_FREQ=1 MHz, BAUD=100 kHz).
// Drives the CPU bus on falling edges and samples outputs away from the rising edge.
module tb_peripheral;
   logic        sysclk = 1'b0, reset = 1'b1, clk = 1'b0, rd = 1'b0, wr = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [7:0]  switch = '0;
   logic [31:0] rdata;
   logic [7:0]  led;
   logic [11:0] digi;
   logic        irqout, rxd = 1'b1, txd;

   int checks = 0;
   int errors = 0;

   peripheral #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
      .sysclk(sysclk), .reset(reset), .clk(clk), .rd(rd), .wr(wr),
      .addr(addr), .wdata(wdata), .switch(switch), .rdata(rdata),
      .led(led), .digi(digi), .irqout(irqout),
      .PC_Uart_rxd(rxd), .PC_Uart_txd(txd)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // called at a falling edge; returns at the next falling edge
   task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
      wr = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
      rd = 1'b1; addr = a;
      #1 d = rdata;
      @(negedge clk);
      rd = 1'b0;
   endtask

   task automatic rx_send(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (10) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (10) @(negedge clk);
      rxd = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   logic [9:0]  tx_frame;
   logic [31:0] d;

   initial begin
      // reset state
      #35;
      chk("rst_led", {24'd0, led}, 32'h0);
      chk("rst_digi", {20'd0, digi}, 32'h0);
      chk("rst_irq", {31'd0, irqout}, 32'h0);
      chk("rst_txd", {31'd0, txd}, 32'h1);
      chk("rst_rdata", rdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // UART TX of 0x2D: start, 1,0,1,1,0,1,0,0, stop (index 0 sent first)
      tx_frame = 10'b1_0010_1101_0;
      wr_reg(32'h4000_0018, 32'h2D);
      repeat (5) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("tx_bit%0d", k), {31'd0, txd}, {31'd0, tx_frame[k]});
         if (k == 3) begin
            wr_reg(32'h4000_0018, 32'h77);           // ignored while busy
            repeat (9) @(negedge clk);
         end else if (k == 4) begin
            rd_reg(32'h4000_0018, d);
            chk("tx_reg_kept", d, 32'h2D);
            repeat (9) @(negedge clk);
         end else if (k == 5) begin
            rd_reg(32'h4000_0020, d);
            chk("tx_busy", d, 32'h4);
            repeat (9) @(negedge clk);
         end else begin
            repeat (10) @(negedge clk);
         end
      end
      rd_reg(32'h4000_0020, d);
      chk("tx_done_set", d, 32'h2);
      rd_reg(32'h4000_0020, d);
      chk("tx_done_clr", d, 32'h0);

      // UART RX
      rx_send(8'h23, 1'b1);
      rd_reg(32'h4000_0020, d);
      chk("rx_valid1", d, 32'h1);
      rd_reg(32'h4000_001C, d);
      chk("rx_byte1", d, 32'h23);
      rd_reg(32'h4000_0020, d);
      chk("rx_valid_clr", d, 32'h0);
      rx_send(8'h41, 1'b1);
      rd_reg(32'h4000_001C, d);
      chk("rx_byte2", d, 32'h41);
      rx_send(8'h55, 1'b0);
      rd_reg(32'h4000_0020, d);
      chk("rx_bad_stop", d, 32'h0);
      rd_reg(32'h4000_001C, d);
      chk("rx_bad_keep", d, 32'h41);

      // timer wrap
      wr_reg(32'h4000_0000, 32'hFFFF_FFFC);
      wr_reg(32'h4000_0004, 32'hFFFF_FFFE);
      wr_reg(32'h4000_0008, 32'h3);
      chk("tmr_irq_pre", {31'd0, irqout}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rd_reg(32'h4000_0004, d);
      chk("tmr_reload", d, 32'hFFFF_FFFC);
      rd_reg(32'h4000_0008, d);
      chk("tmr_status", d, 32'h7);
      chk("tmr_irq", {31'd0, irqout}, 32'h1);
      wr_reg(32'h4000_0008, 32'h3);
      chk("tmr_irq_clr", {31'd0, irqout}, 32'h0);
      wr_reg(32'h4000_0008, 32'h0);

      // LED / digi / switch
      switch = 8'h5A;
      wr_reg(32'h4000_000C, 32'hA5);
      wr_reg(32'h4000_0014, 32'hF3C);
      chk("led_out", {24'd0, led}, 32'hA5);
      chk("digi_out", {20'd0, digi}, 32'hF3C);
      rd_reg(32'h4000_000C, d);
      chk("led_rd", d, 32'hA5);
      rd_reg(32'h4000_0010, d);
      chk("sw_rd", d, 32'h5A);
      rd_reg(32'h4000_0014, d);
      chk("digi_rd", d, 32'hF3C);
      rd_reg(32'h4000_0040, d);
      chk("unmapped_rd", d, 32'h0);
      addr = 32'h4000_000C;
      #1 chk("rd_low", rdata, 32'h0);
      @(negedge clk);

      // reset during TX data bit 0 (byte 0x00 -> line low)
      wr_reg(32'h4000_0018, 32'h00);
      repeat (14) @(negedge clk);
      chk("tx_mid_low", {31'd0, txd}, 32'h0);
      reset = 1'b1;
      #1 chk("tx_rst_high", {31'd0, txd}, 32'h1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      rd_reg(32'h4000_0020, d);
      chk("tx_rst_idle", d, 32'h0);
      repeat (3) @(negedge clk);
      chk("tx_rst_stay", {31'd0, txd}, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
